aes_stream_ctrl: RTL

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

---
 rtl/aes_stream_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - AES-256 core stream controller: key load, paced issue, in-order result FIFO.
module aes_stream_ctrl #(
  parameter int unsigned ISSUE_GAP = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic [255:0] key_in_i,
  input  logic         key_load_i,
  output logic         key_ready_o,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         err_ovf_o,
  output logic [127:0] core_plain_text_o,
  output logic [255:0] core_cipher_key_o,
  output logic         core_key_valid_o,
  output logic         core_start_o,
  output logic         core_last_o,
  input  logic [127:0] core_cipher_text_i,
  input  logic         core_ready_text_i,
  input  logic         core_pipe_ready_i,
  input  logic         core_done_i
);

  localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_KEY_WAIT, S_READY, S_STREAM, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [255:0]    key_q, key_d;
  logic            kvalid_q, kvalid_d;
  logic            kv_cnt_q, kv_cnt_d;
  logic            pipe_prev_q;
  logic            start_q, start_d;
  logic [127:0]    plain_q, plain_d;
  logic            last_q, last_d;
  logic [7:0]      gap_q, gap_d;
  logic [CW-1:0]   infl_q, infl_d;
  logic [CW-1:0]   o_cnt_q, o_cnt_d;
  logic [AW-1:0]   tag_wr_q, tag_rd_q, o_wr_q, o_rd_q;
  logic            err_q;
  logic            tag_mem [OUT_DEPTH];
  logic [128:0]    out_mem [OUT_DEPTH];

  logic            xfer, res, push, pop, o_full, ovf;
  logic [CW:0]     occ;
  logic            unused_done;

  assign unused_done = core_done_i;

  // Occupancy counts both blocks still inside the core and results waiting to drain.
  assign occ        = {1'b0, infl_q} + {1'b0, o_cnt_q};
  assign in_ready_o = (state_q == S_READY || state_q == S_STREAM) && (gap_q == 8'd0)
                      && (occ < (CW+1)'(OUT_DEPTH));
  assign xfer       = in_valid_i && in_ready_o;
  assign res        = core_ready_text_i && (infl_q != '0);
  assign out_valid_o = (o_cnt_q != '0);
  assign pop        = out_valid_o && out_ready_i;
  assign o_full     = (o_cnt_q == CW'(OUT_DEPTH));
  assign push       = res && (!o_full || pop);
  assign ovf        = res && o_full && !pop;

  assign out_data_o        = out_valid_o ? out_mem[o_rd_q][127:0] : 128'd0;
  assign out_last_o        = out_valid_o ? out_mem[o_rd_q][128] : 1'b0;
  assign key_ready_o       = (state_q == S_READY) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign busy_o            = (state_q == S_KEY_WAIT) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign err_ovf_o         = err_q;
  assign core_plain_text_o = plain_q;
  assign core_cipher_key_o = key_q;
  assign core_key_valid_o  = kvalid_q;
  assign core_start_o      = start_q;
  assign core_last_o       = last_q;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    kvalid_d = kvalid_q;
    kv_cnt_d = kv_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (key_load_i) begin
          state_d  = S_KEY_WAIT;
          key_d    = key_in_i;
          kvalid_d = 1'b0;
          kv_cnt_d = 1'b1;
        end
      end
      S_KEY_WAIT: begin
        if (!kvalid_q) begin
          if (kv_cnt_q) kv_cnt_d = 1'b0;
          else          kvalid_d = 1'b1;
        end else if (core_pipe_ready_i && !pipe_prev_q) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        // A block transfer in the same cycle wins over a key reload.
        if (xfer) begin
          state_d = in_last_i ? S_DRAIN : S_STREAM;
        end else if (key_load_i) begin
          state_d  = S_KEY_WAIT;
          key_d    = key_in_i;
          kvalid_d = 1'b0;
          kv_cnt_d = 1'b1;
        end
      end
      S_STREAM: if (xfer && in_last_i) state_d = S_DRAIN;
      S_DRAIN:  if (infl_q == '0 && o_cnt_q == '0) state_d = S_READY;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d = xfer;
    plain_d = xfer ? in_data_i : plain_q;
    last_d  = xfer ? in_last_i : last_q;
    gap_d   = xfer ? 8'(ISSUE_GAP - 1) : ((gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0);
    infl_d  = infl_q + CW'(xfer) - CW'(res);
    o_cnt_d = o_cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      kvalid_q    <= 1'b0;
      kv_cnt_q    <= 1'b0;
      pipe_prev_q <= 1'b0;
      start_q     <= 1'b0;
      plain_q     <= '0;
      last_q      <= 1'b0;
      gap_q       <= '0;
      infl_q      <= '0;
      o_cnt_q     <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      o_wr_q      <= '0;
      o_rd_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      kvalid_q    <= kvalid_d;
      kv_cnt_q    <= kv_cnt_d;
      pipe_prev_q <= core_pipe_ready_i;
      start_q     <= start_d;
      plain_q     <= plain_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      infl_q      <= infl_d;
      o_cnt_q     <= o_cnt_d;
      tag_wr_q    <= tag_wr_q + AW'(xfer);
      tag_rd_q    <= tag_rd_q + AW'(res);
      o_wr_q      <= o_wr_q + AW'(push);
      o_rd_q      <= o_rd_q + AW'(pop);
      err_q       <= err_q | ovf;
    end
  end

  // Storage needs no reset: the counters define which entries are live.
  always_ff @(posedge clock_i) begin
    if (xfer) tag_mem[tag_wr_q] <= in_last_i;
    if (push) out_mem[o_wr_q] <= {tag_mem[tag_rd_q], core_cipher_text_i};
  end

endmodule
